exe_hazard_ctrl: RTL

Pipeline hazard and sequencing controller for the in-order RV32I core. Sits beside decode and the execute stage. It decides each cycle whether the decoded instruction issues into execute, and drives the execute stage's rs1/rs2 forward selects. It inserts bubbles for load-use and MEM-distance dependencies, squashes wrong-path instructions on a control-flow redirect, and freezes the pipe while memory is busy.

---
 rtl/rv_pipe_pkg.sv | 36 +++
 rtl/exe_hazard_ctrl_inst_use_decode.sv | 63 ++++++
 rtl/exe_hazard_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/rv_pipe_pkg.sv
// rv_pipe_pkg: shared definitions for the RV32I pipeline control logic.
//   - RV32I major opcodes used for operand/destination classification
//   - stage_desc_t: per-stage scoreboard descriptor {valid, rd, wr, load}
//   - hazard controller state encoding
//   - src_hit(): does a decoded source operand depend on a stage descriptor
package rv_pipe_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // wr is only set for a non-x0 destination, so x0 never matches as a producer.
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       wr;
        logic       load;
    } stage_desc_t;

    typedef logic [1:0] state_t;

    localparam state_t ST_RUN   = 2'd0;
    localparam state_t ST_STALL = 2'd1;
    localparam state_t ST_FLUSH = 2'd2;

    function automatic logic src_hit(logic used, logic [4:0] rs, stage_desc_t d);
        return used && (rs != 5'd0) && d.valid && d.wr && (d.rd == rs);
    endfunction

endpackage

// File: rtl/exe_hazard_ctrl_inst_use_decode.sv
// inst_use_decode: combinational register-usage classifier for one RV32I instruction.
//   inst_i      - 32-bit instruction word
//   rs1_o/rs2_o - source register fields
//   rd_o        - destination register field
//   uses_rs1_o  - instruction reads rs1
//   uses_rs2_o  - instruction reads rs2
//   writes_rd_o - instruction writes rd (x0 is filtered by the consumer)
//   is_load_o   - instruction is a LOAD
module inst_use_decode
    import rv_pipe_pkg::*;
(
    input  logic [31:0] inst_i,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o,
    output logic [4:0]  rd_o,
    output logic        uses_rs1_o,
    output logic        uses_rs2_o,
    output logic        writes_rd_o,
    output logic        is_load_o
);

    logic [6:0] opcode;
    logic       unused_funct;

    assign opcode       = inst_i[6:0];
    assign rd_o         = inst_i[11:7];
    assign rs1_o        = inst_i[19:15];
    assign rs2_o        = inst_i[24:20];
    // funct/immediate bits play no part in register usage.
    assign unused_funct = ^{inst_i[31:25], inst_i[14:12]};

    always_comb begin
        uses_rs1_o  = 1'b0;
        uses_rs2_o  = 1'b0;
        writes_rd_o = 1'b0;
        is_load_o   = 1'b0;
        case (opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL: begin
                writes_rd_o = 1'b1;
            end
            OPC_JALR, OPC_OP_IMM: begin
                uses_rs1_o  = 1'b1;
                writes_rd_o = 1'b1;
            end
            OPC_BRANCH, OPC_STORE: begin
                uses_rs1_o = 1'b1;
                uses_rs2_o = 1'b1;
            end
            OPC_LOAD: begin
                uses_rs1_o  = 1'b1;
                writes_rd_o = 1'b1;
                is_load_o   = 1'b1;
            end
            OPC_OP: begin
                uses_rs1_o  = 1'b1;
                uses_rs2_o  = 1'b1;
                writes_rd_o = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/exe_hazard_ctrl.sv
// exe_hazard_ctrl: issue / stall / flush control and forward selects for the execute stage.
//   clk, rst           - core clock, synchronous active-high reset
//   dec_inst/dec_valid - instruction in decode and its valid flag
//   exe_redirect       - execute holds a taken control transfer
//   mem_busy           - memory stage cannot advance; whole pipe holds
//   issue              - comb: dec_inst moves into execute at the next edge
//   stall_fetch        - comb: fetch/decode hold their instruction
//   flush              - comb: squash fetch and decode contents
//   exe_valid          - reg: execute holds a real instruction
//   exe_rs1/2_forward  - reg: execute takes rs1/rs2 from its own result register
module exe_hazard_ctrl
    import rv_pipe_pkg::*;
#(
    parameter int unsigned REFILL_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dec_inst,
    input  logic        dec_valid,
    input  logic        exe_redirect,
    input  logic        mem_busy,
    output logic        issue,
    output logic        stall_fetch,
    output logic        flush,
    output logic        exe_valid,
    output logic        exe_rs1_forward,
    output logic        exe_rs2_forward
);

    localparam logic [2:0] RefillCnt = 3'(REFILL_CYCLES);

    logic [4:0] dec_rs1, dec_rs2, dec_rd;
    logic       dec_uses_rs1, dec_uses_rs2, dec_writes_rd, dec_is_load;

    inst_use_decode u_decode (
        .inst_i      (dec_inst),
        .rs1_o       (dec_rs1),
        .rs2_o       (dec_rs2),
        .rd_o        (dec_rd),
        .uses_rs1_o  (dec_uses_rs1),
        .uses_rs2_o  (dec_uses_rs2),
        .writes_rd_o (dec_writes_rd),
        .is_load_o   (dec_is_load)
    );

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    stage_desc_t sb_exe_q, sb_exe_d;
    stage_desc_t sb_mem_q, sb_mem_d;
    stage_desc_t sb_wb_q, sb_wb_d;
    logic        fwd1_q, fwd1_d;
    logic        fwd2_q, fwd2_d;
    logic        unused_wb;

    logic rs1_exe_hit, rs2_exe_hit, load_hit, mem_hit;

    assign rs1_exe_hit = src_hit(dec_uses_rs1, dec_rs1, sb_exe_q);
    assign rs2_exe_hit = src_hit(dec_uses_rs2, dec_rs2, sb_exe_q);
    assign load_hit    = (rs1_exe_hit || rs2_exe_hit) && sb_exe_q.load;
    assign mem_hit     = src_hit(dec_uses_rs1, dec_rs1, sb_mem_q) ||
                         src_hit(dec_uses_rs2, dec_rs2, sb_mem_q);

    // WB-distance dependencies resolve via register-file write-through, so the
    // WB descriptor is tracked but never consulted.
    assign unused_wb = ^sb_wb_q;

    always_comb begin
        issue       = 1'b0;
        stall_fetch = 1'b0;
        flush       = 1'b0;
        state_d     = state_q;
        cnt_d       = cnt_q;
        sb_exe_d    = sb_exe_q;
        sb_mem_d    = sb_mem_q;
        sb_wb_d     = sb_wb_q;
        fwd1_d      = fwd1_q;
        fwd2_d      = fwd2_q;
        if (rst || mem_busy) begin
            stall_fetch = 1'b1;
        end else begin
            sb_mem_d = sb_exe_q;
            sb_wb_d  = sb_mem_q;
            sb_exe_d = '0;
            fwd1_d   = 1'b0;
            fwd2_d   = 1'b0;
            if (exe_redirect) begin
                flush   = 1'b1;
                state_d = ST_FLUSH;
                cnt_d   = RefillCnt;
            end else begin
                case (state_q)
                    ST_RUN: begin
                        // The detecting cycle is itself the first bubble; cnt holds the
                        // bubbles still owed after it (load-use owes 1, MEM-distance 0).
                        if (dec_valid && load_hit) begin
                            stall_fetch = 1'b1;
                            state_d     = ST_STALL;
                            cnt_d       = 3'd1;
                        end else if (dec_valid && mem_hit) begin
                            stall_fetch = 1'b1;
                        end else if (dec_valid) begin
                            issue          = 1'b1;
                            sb_exe_d.valid = 1'b1;
                            sb_exe_d.rd    = dec_rd;
                            sb_exe_d.wr    = dec_writes_rd && (dec_rd != 5'd0);
                            sb_exe_d.load  = dec_is_load;
                            fwd1_d         = rs1_exe_hit;
                            fwd2_d         = rs2_exe_hit;
                        end
                    end
                    ST_STALL, ST_FLUSH: begin
                        stall_fetch = 1'b1;
                        if (cnt_q <= 3'd1) begin
                            state_d = ST_RUN;
                            cnt_d   = 3'd0;
                        end else begin
                            cnt_d = cnt_q - 3'd1;
                        end
                    end
                    default: begin
                        state_d = ST_RUN;
                        cnt_d   = 3'd0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            cnt_q    <= 3'd0;
            sb_exe_q <= '0;
            sb_mem_q <= '0;
            sb_wb_q  <= '0;
            fwd1_q   <= 1'b0;
            fwd2_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sb_exe_q <= sb_exe_d;
            sb_mem_q <= sb_mem_d;
            sb_wb_q  <= sb_wb_d;
            fwd1_q   <= fwd1_d;
            fwd2_q   <= fwd2_d;
        end
    end

    assign exe_valid       = sb_exe_q.valid;
    assign exe_rs1_forward = fwd1_q;
    assign exe_rs2_forward = fwd2_q;

endmodule
